wb_stage_buffered: RTL

//  Final pipeline stage, parametrised successor of the single-cycle write-back unit. Accepts retired

---
 rtl/wb_stage_buffered_pkg.sv | 36 +++
 rtl/wb_stage_buffered_load_align.sv | 36 +++
 rtl/wb_stage_buffered.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wb_stage_buffered_pkg.sv
// Shared definitions for the buffered write-back stage: opcodes, load
// size/sign encodings and the decoded write-back entry.
package wb_pkg;

    localparam int WB_MAX_XLEN = 64;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Data is held at the widest supported XLEN; narrower builds use the low bits.
    typedef struct packed {
        logic                   we;
        logic [4:0]             rd;
        logic [WB_MAX_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_buffered_load_align.sv
// Load data alignment: shifts the naturally aligned memory word down by the
// byte offset, then sign- or zero-extends according to the load size.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]            load_data_i,
    input  logic [$clog2(XLEN/8)-1:0]  offset_i,
    input  logic [2:0]                 funct3_i,
    output logic [XLEN-1:0]            data_o
);

    logic [XLEN-1:0] shifted;
    logic [63:0]     wide;
    logic [63:0]     ext;

    // Extension is done at 64 bits and truncated, so XLEN=32 gets LD/LWU == LW for free.
    always_comb begin
        shifted = load_data_i >> {offset_i, 3'b000};
        wide    = 64'(shifted);
        ext     = {56'd0, wide[7:0]};
        case (funct3_i)
            F3_LB:   ext = {{56{wide[7]}}, wide[7:0]};
            F3_LH:   ext = {{48{wide[15]}}, wide[15:0]};
            F3_LW:   ext = {{32{wide[31]}}, wide[31:0]};
            F3_LD:   ext = wide;
            F3_LBU:  ext = {56'd0, wide[7:0]};
            F3_LHU:  ext = {48'd0, wide[15:0]};
            F3_LWU:  ext = {32'd0, wide[31:0]};
            default: ext = {56'd0, wide[7:0]};
        endcase
        data_o = ext[XLEN-1:0];
    end

endmodule

// File: rtl/wb_stage_buffered.sv
// Buffered write-back stage: decodes retired instructions into register-file
// writes, queues them in a small FIFO behind an output register, and tracks
// pending destinations and the number of retired instructions.
module wb_stage_buffered
    import wb_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rd,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_load_data,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    input  logic              rf_ready,
    output logic [31:0]       pending_rd_mask,
    output logic [CNT_W-1:0]  retire_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int OFF_W = $clog2(XLEN / 8);

    wb_entry_t              fifoMem [DEPTH];
    logic [DEPTH-1:0]       slotValid_q;
    logic [PTR_W-1:0]       rdPtr_q;
    logic [PTR_W-1:0]       wrPtr_q;
    logic [OCC_W-1:0]       occ_q;
    logic [OCC_W-1:0]       occ_d;
    logic                   inReady_q;
    logic                   outValid_q;
    wb_entry_t              outEntry_q;
    logic [CNT_W-1:0]       retire_q;

    wb_entry_t              decoded;
    logic [XLEN-1:0]        loadAligned;
    logic                   accept;
    logic                   outFire;
    logic                   outLoad;
    logic                   pop;
    logic                   push;
    logic                   bypass;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    wb_load_align #(.XLEN(XLEN)) loadAlign (
        .load_data_i (in_load_data),
        .offset_i    (in_alu_result[OFF_W-1:0]),
        .funct3_i    (in_funct3),
        .data_o      (loadAligned)
    );

    // Decode the incoming instruction into a write-back entry; x0 never gets written.
    always_comb begin
        decoded      = '0;
        decoded.rd   = in_rd;
        decoded.we   = 1'b1;
        decoded.data = 64'(in_alu_result);
        case (in_opcode)
            OPC_OP, OPC_OP_IMM, OPC_AUIPC, OPC_LUI:
                decoded.data = 64'(in_alu_result);
            OPC_OP_32, OPC_OP_IMM_32:
                decoded.data = {{32{in_alu_result[31]}}, in_alu_result[31:0]};
            OPC_LOAD:
                decoded.data = 64'(loadAligned);
            OPC_JAL, OPC_JALR:
                decoded.data = 64'(in_pc + XLEN'(4));
            OPC_STORE, OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM:
                decoded.we = 1'b0;
            default:
                decoded.we = 1'b0;
        endcase
        if (in_rd == 5'd0) begin
            decoded.we = 1'b0;
        end
    end

    // Handshake and queue movement; entries without a write leave without waiting on rf_ready.
    always_comb begin
        accept  = in_valid & inReady_q;
        outFire = outValid_q & (rf_ready | ~outEntry_q.we);
        outLoad = ~outValid_q | outFire;
        pop     = outLoad & (occ_q != '0);
        bypass  = accept & outLoad & (occ_q == '0);
        push    = accept & ~bypass;
        occ_d   = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push && pop) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // Control state: pointers, occupancy, registered ready, output register and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            slotValid_q <= '0;
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            occ_q       <= '0;
            inReady_q   <= 1'b0;
            outValid_q  <= 1'b0;
            outEntry_q  <= '0;
            retire_q    <= '0;
        end else begin
            occ_q     <= occ_d;
            inReady_q <= (occ_d < OCC_W'(DEPTH));
            if (push) begin
                slotValid_q[wrPtr_q] <= 1'b1;
                wrPtr_q              <= ptrInc(wrPtr_q);
            end
            if (pop) begin
                slotValid_q[rdPtr_q] <= 1'b0;
                rdPtr_q              <= ptrInc(rdPtr_q);
            end
            if (outLoad) begin
                if (pop) begin
                    outEntry_q <= fifoMem[rdPtr_q];
                    outValid_q <= 1'b1;
                end else if (bypass) begin
                    outEntry_q <= decoded;
                    outValid_q <= 1'b1;
                end else begin
                    outValid_q <= 1'b0;
                end
            end
            retire_q <= retire_q + CNT_W'(outFire);
        end
    end

    // FIFO storage needs no reset because slot validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr_q] <= decoded;
        end
    end

    // Pending destinations from registered state only, so it never depends on this cycle's inputs.
    always_comb begin
        pending_rd_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slotValid_q[i] && fifoMem[i].we) begin
                pending_rd_mask[fifoMem[i].rd] = 1'b1;
            end
        end
        if (outValid_q && outEntry_q.we) begin
            pending_rd_mask[outEntry_q.rd] = 1'b1;
        end
        pending_rd_mask[0] = 1'b0;
    end

    assign in_ready     = inReady_q;
    assign rf_we        = outValid_q & outEntry_q.we;
    assign rf_waddr     = outEntry_q.rd;
    assign rf_wdata     = outEntry_q.data[XLEN-1:0];
    assign retire_count = retire_q;

endmodule
